// File: rtl/circuito_jogo_base.sv
// Memory game core: FSM, round/play counters, 16x4 sequence RAM, idle timer
// and hex 7-segment debug encoders, all on a single rising-edge clock.
module circuito_jogo_base #(
    parameter int unsigned SHOW_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    output logic [3:0] leds,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic       db_iniciar,
    output logic       db_igual,
    output logic       db_tem_jogada,
    output logic       db_timeout,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_rodada
);
    localparam int unsigned TMAX = (TIMEOUT_CYCLES > SHOW_CYCLES) ? TIMEOUT_CYCLES : SHOW_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        MOSTRA         = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARA        = 4'h5,
        PROX_JOGADA    = 4'h6,
        FIM_RODADA     = 4'h7,
        ESPERA_ESCRITA = 4'h8,
        ESCREVE        = 4'h9,
        PROX_RODADA    = 4'hA,
        FIM_GANHOU     = 4'hC,
        FIM_PERDEU     = 4'hD,
        FIM_TIMEOUT    = 4'hE
    } estado_t;

    // Hex digit to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            4'hF:    hex7 = 7'h0E;
            default: hex7 = 7'h7F;
        endcase
    endfunction

    estado_t       state_q, state_d;
    logic [3:0]    rodada_q, rodada_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    jogada_q, jogada_d;
    logic [3:0]    leds_q, leds_d;
    logic          ganhou_q, ganhou_d;
    logic          perdeu_q, perdeu_d;
    logic          pronto_q, pronto_d;
    logic          timeout_q, timeout_d;
    logic          prev_q;
    logic          we_s;
    logic          tem_jogada_s;
    logic          edge_s;
    logic          igual_s;
    logic [3:0]    rdata_s;

    // Power-up contents only; reset deliberately leaves the sequence intact
    logic [3:0] mem_q [16] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                               4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

    assign tem_jogada_s = |botoes;
    assign edge_s       = tem_jogada_s & ~prev_q;
    assign rdata_s      = mem_q[idx_q];
    assign igual_s      = (jogada_q == rdata_s);

    // Next-state and datapath decisions
    always_comb begin
        state_d   = state_q;
        rodada_d  = rodada_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        jogada_d  = jogada_q;
        leds_d    = 4'd0;
        ganhou_d  = ganhou_q;
        perdeu_d  = perdeu_q;
        pronto_d  = pronto_q;
        timeout_d = timeout_q;
        we_s      = 1'b0;
        case (state_q)
            INICIAL: begin
                if (jogar) state_d = PREPARA;
                else       state_d = INICIAL;
            end
            PREPARA: begin
                rodada_d  = 4'd0;
                idx_d     = 4'd0;
                timer_d   = '0;
                jogada_d  = 4'd0;
                ganhou_d  = 1'b0;
                perdeu_d  = 1'b0;
                pronto_d  = 1'b0;
                timeout_d = 1'b0;
                leds_d    = mem_q[0];
                state_d   = MOSTRA;
            end
            MOSTRA: begin
                if (timer_q == TW'(SHOW_CYCLES - 1)) begin
                    timer_d = '0;
                    leds_d  = botoes;
                    state_d = ESPERA;
                end else begin
                    timer_d = timer_q + TW'(1);
                    leds_d  = mem_q[0];
                end
            end
            ESPERA, ESPERA_ESCRITA: begin
                leds_d = botoes;
                if (edge_s) begin
                    jogada_d = botoes;
                    timer_d  = '0;
                    state_d  = (state_q == ESPERA) ? REGISTRA : ESCREVE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    perdeu_d  = 1'b1;
                    pronto_d  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = FIM_TIMEOUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REGISTRA: begin
                timer_d = '0;
                state_d = COMPARA;
            end
            COMPARA: begin
                if (!igual_s) begin
                    perdeu_d = 1'b1;
                    pronto_d = 1'b1;
                    state_d  = FIM_PERDEU;
                end else if (idx_q == rodada_q) begin
                    state_d = FIM_RODADA;
                end else begin
                    state_d = PROX_JOGADA;
                end
            end
            PROX_JOGADA: begin
                idx_d   = idx_q + 4'd1;
                state_d = ESPERA;
            end
            FIM_RODADA: begin
                if (rodada_q == 4'd15) begin
                    ganhou_d = 1'b1;
                    pronto_d = 1'b1;
                    state_d  = FIM_GANHOU;
                end else begin
                    state_d = ESPERA_ESCRITA;
                end
            end
            ESCREVE: begin
                we_s    = 1'b1;
                state_d = PROX_RODADA;
            end
            PROX_RODADA: begin
                rodada_d = rodada_q + 4'd1;
                idx_d    = 4'd0;
                timer_d  = '0;
                state_d  = ESPERA;
            end
            FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                // Flags drop on the restart edge itself, not one cycle later
                if (jogar) begin
                    ganhou_d  = 1'b0;
                    perdeu_d  = 1'b0;
                    pronto_d  = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = PREPARA;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = INICIAL;
        endcase
    end

    // State, counters, flags and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= INICIAL;
            rodada_q  <= 4'd0;
            idx_q     <= 4'd0;
            timer_q   <= '0;
            jogada_q  <= 4'd0;
            leds_q    <= 4'd0;
            ganhou_q  <= 1'b0;
            perdeu_q  <= 1'b0;
            pronto_q  <= 1'b0;
            timeout_q <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rodada_q  <= rodada_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            jogada_q  <= jogada_d;
            leds_q    <= leds_d;
            ganhou_q  <= ganhou_d;
            perdeu_q  <= perdeu_d;
            pronto_q  <= pronto_d;
            timeout_q <= timeout_d;
            prev_q    <= tem_jogada_s;
        end
    end

    // Sequence RAM write port
    always_ff @(posedge clock) begin
        if (reset && we_s) begin
            mem_q[rodada_q + 4'd1] <= jogada_q;
        end
    end

    assign leds           = leds_q;
    assign ganhou         = ganhou_q;
    assign perdeu         = perdeu_q;
    assign pronto         = pronto_q;
    assign db_iniciar     = jogar;
    assign db_igual       = igual_s;
    assign db_tem_jogada  = tem_jogada_s;
    assign db_timeout     = timeout_q;
    assign db_contagem    = hex7(idx_q);
    assign db_memoria     = hex7(rdata_s);
    assign db_estado      = hex7(state_q);
    assign db_jogadafeita = hex7(jogada_q);
    assign db_rodada      = hex7(rodada_q);

endmodule

// File: tb/tb_circuito_jogo_base.sv
// Directed bench for circuito_jogo_base: start/show, round play, RAM write,
// timeout, wrong press, held button and mid-game reset.
module tb_circuito_jogo_base;
    logic       clock;
    logic       reset;
    logic       jogar;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       ganhou, perdeu, pronto;
    logic       db_iniciar, db_igual, db_tem_jogada, db_timeout;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_rodada;

    int n_cmp = 0;
    int n_bad = 0;

    // Active-low {g..a} codes for the hex digits used below
    localparam logic [6:0] SEG_0 = 7'h40, SEG_1 = 7'h79, SEG_2 = 7'h24, SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19, SEG_5 = 7'h12, SEG_7 = 7'h78, SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10, SEG_A = 7'h08, SEG_D = 7'h21, SEG_E = 7'h06;

    circuito_jogo_base dut (
        .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .leds(leds),
        .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
        .db_iniciar(db_iniciar), .db_igual(db_igual), .db_tem_jogada(db_tem_jogada),
        .db_timeout(db_timeout), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_rodada(db_rodada)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; jogar = 1'b0; botoes = 4'd0;
        tick(); tick();
        check_val("rst_state", 32'(db_estado), 32'(SEG_0));
        check_val("rst_leds", 32'(leds), 32'd0);
        check_val("rst_flags", {29'd0, ganhou, perdeu, pronto}, 32'd0);
        check_val("rst_timeout", 32'(db_timeout), 32'd0);
        check_val("rst_idx", 32'(db_contagem), 32'(SEG_0));
        check_val("rst_jogada", 32'(db_jogadafeita), 32'(SEG_0));
        reset = 1'b1;

        // 1: start, show memory[0] for exactly SHOW_CYCLES cycles
        jogar = 1'b1;
        tick();
        check_val("t1_prepara", 32'(db_estado), 32'(SEG_1));
        check_val("t1_iniciar", 32'(db_iniciar), 32'd1);
        tick();
        check_val("t1_mostra", 32'(db_estado), 32'(SEG_2));
        check_val("t1_leds", 32'(leds), 32'd1);
        repeat (8) tick();
        jogar = 1'b0;
        repeat (991) tick();
        check_val("t1_mostra_end", 32'(db_estado), 32'(SEG_2));
        check_val("t1_leds_end", 32'(leds), 32'd1);
        tick();
        check_val("t1_espera", 32'(db_estado), 32'(SEG_3));

        // 2: correct press in round 0
        botoes = 4'b0001;
        tick();
        check_val("t2_registra", 32'(db_estado), 32'(SEG_4));
        tick();
        check_val("t2_compara", 32'(db_estado), 32'(SEG_5));
        check_val("t2_igual", 32'(db_igual), 32'd1);
        tick();
        check_val("t2_fim_rodada", 32'(db_estado), 32'(SEG_7));
        tick();
        check_val("t2_esp_escr", 32'(db_estado), 32'(SEG_8));
        repeat (6) tick();
        check_val("t2_held", 32'(db_estado), 32'(SEG_8));
        botoes = 4'd0;
        tick();

        // 3: new entry 0010 stored at address 1, then round 1 first press
        botoes = 4'b0010;
        tick();
        check_val("t3_escreve", 32'(db_estado), 32'(SEG_9));
        tick();
        check_val("t3_prox_rod", 32'(db_estado), 32'(SEG_A));
        tick();
        check_val("t3_espera", 32'(db_estado), 32'(SEG_3));
        check_val("t3_rodada", 32'(db_rodada), 32'(SEG_1));
        botoes = 4'd0;
        tick();
        botoes = 4'b0001;
        repeat (4) tick();
        check_val("t3_idx", 32'(db_contagem), 32'(SEG_1));
        check_val("t3_ram1", 32'(db_memoria), 32'(SEG_2));
        check_val("t3_flags", {29'd0, ganhou, perdeu, pronto}, 32'd0);
        botoes = 4'd0;
        tick();

        // 4: idle until timeout
        repeat (4998) tick();
        check_val("t4_not_yet", 32'(db_estado), 32'(SEG_3));
        tick();
        check_val("t4_state", 32'(db_estado), 32'(SEG_E));
        check_val("t4_flags", {28'd0, ganhou, perdeu, pronto, db_timeout}, 32'b0111);

        // 5: restart, wrong press in round 0
        jogar = 1'b1;
        tick();
        check_val("t5_prepara", 32'(db_estado), 32'(SEG_1));
        check_val("t5_cleared", {28'd0, ganhou, perdeu, pronto, db_timeout}, 32'd0);
        jogar = 1'b0;
        tick();
        check_val("t5_leds", 32'(leds), 32'd1);
        repeat (1000) tick();
        check_val("t5_espera", 32'(db_estado), 32'(SEG_3));
        botoes = 4'b0100;
        tick(); tick();
        check_val("t5_igual", 32'(db_igual), 32'd0);
        tick();
        check_val("t5_state", 32'(db_estado), 32'(SEG_D));
        check_val("t5_flags", {28'd0, ganhou, perdeu, pronto, db_timeout}, 32'b0110);
        check_val("t5_jogada", 32'(db_jogadafeita), 32'(SEG_4));
        botoes = 4'd0;

        // 6: held button counts once; reset mid-game aborts
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        tick();
        repeat (1000) tick();
        botoes = 4'b0001;
        repeat (50) tick();
        check_val("t6_once", 32'(db_estado), 32'(SEG_8));
        check_val("t6_tem", 32'(db_tem_jogada), 32'd1);
        botoes = 4'd0;
        tick();
        reset = 1'b0;
        tick();
        check_val("t6_rst_state", 32'(db_estado), 32'(SEG_0));
        check_val("t6_rst_flags", {28'd0, ganhou, perdeu, pronto, db_timeout}, 32'd0);
        check_val("t6_rst_leds", 32'(leds), 32'd0);
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
